// File: rtl/lock_seq_ctrl_if.sv
// Keypad/status bundle for the combination lock sequencer.
// master: keypad side that strobes digits and commands; slave: the sequencer.
interface lock_seq_ctrl_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       cancel;
  logic       relock;
  logic       prog;
  logic [1:0] disp_mode;
  logic [2:0] entry_idx;
  logic [1:0] fail_count;
  logic       unlocked;
  logic       ready;

  modport master (
    output digit_valid, digit, cancel, relock, prog,
    input  disp_mode, entry_idx, fail_count, unlocked, ready
  );

  modport slave (
    input  digit_valid, digit, cancel, relock, prog,
    output disp_mode, entry_idx, fail_count, unlocked, ready
  );
endinterface

// File: rtl/lock_seq_ctrl.sv
// Combination lock sequencer: digit entry with running compare, failure
// counting with timed CLOSED/LOCKOUT back-off, and in-place reprogramming.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ENTRY   | accepting digits, comparing each against the stored code
// OPEN    | correct code entered; waiting for relock or prog
// CLOSED  | wrong code; result held for CLOSED_HOLD cycles
// LOCKOUT | MAX_FAIL consecutive failures; all inputs ignored
// PROG    | collecting a new code into the shadow register
module lock_seq_ctrl #(
  parameter int          CODE_LEN       = 6,
  parameter int          MAX_FAIL       = 3,
  parameter int          CLOSED_HOLD    = 8,
  parameter int          LOCKOUT_CYCLES = 64,
  parameter logic [23:0] DEFAULT_CODE   = 24'h722297
) (
  input  logic           clk,
  input  logic           reset,
  lock_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_OPEN,
    S_CLOSED,
    S_LOCKOUT,
    S_PROG
  } state_t;

  localparam int CW      = CODE_LEN * 4;
  localparam int TMR_MAX = (CLOSED_HOLD > LOCKOUT_CYCLES) ? CLOSED_HOLD : LOCKOUT_CYCLES;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [2:0]    LAST_IDX    = 3'(CODE_LEN - 1);
  localparam logic [1:0]    FAIL_MAX    = 2'(MAX_FAIL);
  localparam logic [TW-1:0] CLOSED_LOAD = TW'(CLOSED_HOLD - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);

  state_t        state_q,  state_d;
  logic [CW-1:0] code_q,   code_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [2:0]    idx_q,    idx_d;
  logic          err_q,    err_d;
  logic [1:0]    fail_q,   fail_d;
  logic [TW-1:0] tmr_q,    tmr_d;

  logic [3:0] code_digit;
  logic       digit_bad;
  logic       err_new;
  logic [1:0] fail_inc;

  // State and datapath registers with synchronous reset to the factory code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_ENTRY;
      code_q   <= CW'(DEFAULT_CODE);
      shadow_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      fail_q   <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
    end
  end

  // Next-state logic; the compare is folded into the digit-accept edge so the
  // verdict appears the cycle after the last strobe.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q;

    // First digit of the code sits in the top nibble.
    code_digit = code_q[(CW - 4) - 4 * int'(idx_q) +: 4];
    digit_bad  = (bus.digit > 4'd9);
    err_new    = err_q | digit_bad | (bus.digit != code_digit);
    fail_inc   = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 2'd1;

    case (state_q)
      S_ENTRY: begin
        if (bus.cancel) begin
          idx_d = '0;
          err_d = 1'b0;
        end else if (bus.digit_valid) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            err_d = 1'b0;
            if (!err_new) begin
              state_d = S_OPEN;
              fail_d  = '0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == FAIL_MAX) begin
                state_d = S_LOCKOUT;
                tmr_d   = LOCK_LOAD;
              end else begin
                state_d = S_CLOSED;
                tmr_d   = CLOSED_LOAD;
              end
            end
          end else begin
            idx_d = idx_q + 3'd1;
            err_d = err_new;
          end
        end
      end

      S_CLOSED: begin
        if (tmr_q == '0) begin
          state_d = S_ENTRY;
          err_d   = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = S_ENTRY;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      S_OPEN: begin
        if (bus.relock) begin
          state_d = S_ENTRY;
        end else if (bus.prog) begin
          state_d = S_PROG;
          idx_d   = '0;
        end
      end

      S_PROG: begin
        if (bus.cancel || (bus.digit_valid && digit_bad)) begin
          state_d = S_OPEN;
          idx_d   = '0;
        end else if (bus.digit_valid) begin
          shadow_d[(CW - 4) - 4 * int'(idx_q) +: 4] = bus.digit;
          if (idx_q == LAST_IDX) begin
            // Commit the whole new code at once; a partial pass never leaks.
            code_d  = shadow_d;
            idx_d   = '0;
            state_d = S_ENTRY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = S_ENTRY;
        idx_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Moore status outputs decoded from the current state.
  always_comb begin
    bus.entry_idx  = idx_q;
    bus.fail_count = fail_q;
    bus.unlocked   = (state_q == S_OPEN) || (state_q == S_PROG);
    bus.ready      = (state_q == S_ENTRY) || (state_q == S_PROG);
    case (state_q)
      S_CLOSED:  bus.disp_mode = 2'b01;
      S_OPEN:    bus.disp_mode = 2'b10;
      S_LOCKOUT: bus.disp_mode = 2'b11;
      default:   bus.disp_mode = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Bench for lock_seq_ctrl: directed scenarios plus a randomized run, all
// checked against a queue-based model of the lock's behaviour.
module tb_lock_seq_ctrl;

  localparam int M_ENTRY = 0, M_CLOSED = 1, M_OPEN = 2, M_LOCK = 3, M_PROG = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lock_seq_ctrl_if bus ();

  lock_seq_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: the digits typed so far are kept in a queue and the
  // whole entry is judged at once against the stored code array.
  int m_mode;
  int m_code[6];
  int m_q[$];
  int m_fail;
  int m_timer;

  int c_def[6]    = '{7, 2, 2, 2, 9, 7};
  int c_wrong[6]  = '{7, 2, 2, 2, 9, 6};
  int c_new[6]    = '{1, 2, 3, 4, 5, 6};

  function automatic logic [1:0] exp_disp();
    case (m_mode)
      M_CLOSED: return 2'b01;
      M_OPEN:   return 2'b10;
      M_LOCK:   return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] exp_idx();
    return (m_mode == M_ENTRY || m_mode == M_PROG) ? 3'(m_q.size()) : 3'd0;
  endfunction

  task automatic step(input bit rst, input bit v, input int d, input bit c,
                      input bit rl, input bit pg);
    int ok;
    reset           = rst;
    bus.digit_valid = v;
    bus.digit       = 4'(d);
    bus.cancel      = c;
    bus.relock      = rl;
    bus.prog        = pg;
    @(posedge clk);
    if (rst) begin
      m_mode = M_ENTRY; m_code = c_def; m_q.delete(); m_fail = 0; m_timer = 0;
    end else begin
      case (m_mode)
        M_ENTRY: begin
          if (c) m_q.delete();
          else if (v) begin
            m_q.push_back(d);
            if (m_q.size() == 6) begin
              ok = 1;
              for (int i = 0; i < 6; i++) if (m_q[i] != m_code[i]) ok = 0;
              m_q.delete();
              if (ok != 0) begin
                m_mode = M_OPEN; m_fail = 0;
              end else begin
                m_fail = (m_fail < 3) ? m_fail + 1 : 3;
                if (m_fail == 3) begin m_mode = M_LOCK; m_timer = 64; end
                else begin m_mode = M_CLOSED; m_timer = 8; end
              end
            end
          end
        end
        M_CLOSED, M_LOCK: begin
          m_timer--;
          if (m_timer == 0) begin
            if (m_mode == M_LOCK) m_fail = 0;
            m_mode = M_ENTRY;
          end
        end
        M_OPEN: begin
          if (rl) m_mode = M_ENTRY;
          else if (pg) begin m_mode = M_PROG; m_q.delete(); end
        end
        default: begin
          if (c || (v && d > 9)) begin m_mode = M_OPEN; m_q.delete(); end
          else if (v) begin
            m_q.push_back(d);
            if (m_q.size() == 6) begin
              for (int i = 0; i < 6; i++) m_code[i] = m_q[i];
              m_q.delete();
              m_mode = M_ENTRY;
            end
          end
        end
      endcase
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input int d);
    step(0, 1, d, 0, 0, 0);
  endtask

  task automatic enter(input int c[6]);
    for (int i = 0; i < 6; i++) key(c[i]);
  endtask

  task automatic wait_entry();
    for (int i = 0; i < 100 && m_mode != M_ENTRY; i++) idle();
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    checks += 5;
    if (bus.disp_mode !== 2'b00) begin errors++; $display("FAIL reset_disp: got %b want 00", bus.disp_mode); end
    if (bus.entry_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.entry_idx); end
    if (bus.fail_count !== 2'd0) begin errors++; $display("FAIL reset_fail: got %0d want 0", bus.fail_count); end
    if (bus.unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %b want 0", bus.unlocked); end
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_open();
    step(1, 0, 0, 0, 0, 0);
    enter(c_def);
    checks += 4;
    if (bus.disp_mode !== 2'b10) begin errors++; $display("FAIL open_disp: got %b want 10", bus.disp_mode); end
    if (bus.unlocked !== 1'b1) begin errors++; $display("FAIL open_unlocked: got %b want 1", bus.unlocked); end
    if (bus.fail_count !== 2'd0) begin errors++; $display("FAIL open_fail: got %0d want 0", bus.fail_count); end
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL open_ready: got %b want 0", bus.ready); end
    step(0, 0, 0, 0, 1, 1);
    checks++;
    if (bus.disp_mode !== 2'b00 || bus.unlocked !== 1'b0) begin
      errors++; $display("FAIL relock: got disp %b unl %b want 00 0", bus.disp_mode, bus.unlocked);
    end
  endtask

  task automatic test_closed();
    step(1, 0, 0, 0, 0, 0);
    enter(c_wrong);
    checks++;
    if (bus.fail_count !== 2'd1) begin errors++; $display("FAIL closed_fail: got %0d want 1", bus.fail_count); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.disp_mode !== 2'b01 || bus.entry_idx !== 3'd0) begin
        errors++; $display("FAIL closed_hold[%0d]: got disp %b idx %0d want 01 0", i, bus.disp_mode, bus.entry_idx);
      end
      key(7);
    end
    checks += 2;
    if (bus.disp_mode !== 2'b00 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL closed_exit: got disp %b rdy %b want 00 1", bus.disp_mode, bus.ready);
    end
    if (bus.fail_count !== 2'd1) begin errors++; $display("FAIL closed_exit_fail: got %0d want 1", bus.fail_count); end
  endtask

  task automatic test_lockout();
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      enter(c_wrong);
      if (n < 2) wait_entry();
    end
    checks++;
    if (bus.fail_count !== 2'd3) begin errors++; $display("FAIL lock_fail: got %0d want 3", bus.fail_count); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (bus.disp_mode !== 2'b11 || bus.entry_idx !== 3'd0 || bus.unlocked !== 1'b0) begin
        errors++; $display("FAIL lock_hold[%0d]: got disp %b idx %0d unl %b want 11 0 0", i, bus.disp_mode, bus.entry_idx, bus.unlocked);
      end
      step(0, 1, c_def[i % 6], $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    checks += 2;
    if (bus.disp_mode !== 2'b00 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL lock_exit: got disp %b rdy %b want 00 1", bus.disp_mode, bus.ready);
    end
    if (bus.fail_count !== 2'd0) begin errors++; $display("FAIL lock_exit_fail: got %0d want 0", bus.fail_count); end
  endtask

  task automatic test_cancel();
    step(1, 0, 0, 0, 0, 0);
    enter(c_wrong);
    wait_entry();
    key(7); key(2); key(2);
    checks++;
    if (bus.entry_idx !== 3'd3) begin errors++; $display("FAIL cancel_pre_idx: got %0d want 3", bus.entry_idx); end
    step(0, 1, 2, 1, 0, 0);
    checks += 2;
    if (bus.entry_idx !== 3'd0) begin errors++; $display("FAIL cancel_idx: got %0d want 0", bus.entry_idx); end
    if (bus.fail_count !== 2'd1) begin errors++; $display("FAIL cancel_fail: got %0d want 1", bus.fail_count); end
    enter(c_def);
    checks++;
    if (bus.disp_mode !== 2'b10 || bus.fail_count !== 2'd0) begin
      errors++; $display("FAIL cancel_then_open: got disp %b fail %0d want 10 0", bus.disp_mode, bus.fail_count);
    end
  endtask

  task automatic test_prog();
    step(1, 0, 0, 0, 0, 0);
    enter(c_def);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.disp_mode !== 2'b00 || bus.unlocked !== 1'b1 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL prog_enter: got disp %b unl %b rdy %b want 00 1 1", bus.disp_mode, bus.unlocked, bus.ready);
    end
    enter(c_new);
    checks++;
    if (bus.disp_mode !== 2'b00 || bus.unlocked !== 1'b0 || bus.entry_idx !== 3'd0) begin
      errors++; $display("FAIL prog_commit: got disp %b unl %b idx %0d want 00 0 0", bus.disp_mode, bus.unlocked, bus.entry_idx);
    end
    enter(c_new);
    checks++;
    if (bus.disp_mode !== 2'b10) begin errors++; $display("FAIL prog_new_opens: got %b want 10", bus.disp_mode); end
    step(0, 0, 0, 0, 1, 0);
    enter(c_def);
    checks++;
    if (bus.disp_mode !== 2'b01) begin errors++; $display("FAIL prog_old_fails: got %b want 01", bus.disp_mode); end
  endtask

  task automatic test_prog_abort();
    wait_entry();
    enter(c_new);
    step(0, 0, 0, 0, 0, 1);
    key(1); key(2); key(12);
    checks++;
    if (bus.disp_mode !== 2'b10 || bus.entry_idx !== 3'd0) begin
      errors++; $display("FAIL abort_open: got disp %b idx %0d want 10 0", bus.disp_mode, bus.entry_idx);
    end
    step(0, 0, 0, 0, 1, 0);
    enter(c_new);
    checks++;
    if (bus.disp_mode !== 2'b10) begin errors++; $display("FAIL abort_code_kept: got %b want 10", bus.disp_mode); end
    step(0, 0, 0, 0, 0, 1);
    key(1); key(2);
    step(1, 1, 3, 0, 0, 0);
    checks++;
    if (bus.disp_mode !== 2'b00 || bus.unlocked !== 1'b0 || bus.entry_idx !== 3'd0) begin
      errors++; $display("FAIL prog_reset: got disp %b unl %b idx %0d want 00 0 0", bus.disp_mode, bus.unlocked, bus.entry_idx);
    end
    enter(c_def);
    checks++;
    if (bus.disp_mode !== 2'b10) begin errors++; $display("FAIL reset_code_default: got %b want 10", bus.disp_mode); end
  endtask

  task automatic test_random();
    int d;
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      if (m_mode == M_ENTRY && m_q.size() < 6 && $urandom_range(0, 3) != 0) d = m_code[m_q.size()];
      else if ($urandom_range(0, 9) == 0) d = $urandom_range(10, 15);
      else d = $urandom_range(0, 9);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1), d, $urandom_range(0, 15) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      checks += 5;
      if (bus.disp_mode !== exp_disp()) begin errors++; $display("FAIL rnd_disp@%0d: got %b want %b", n, bus.disp_mode, exp_disp()); end
      if (bus.entry_idx !== exp_idx()) begin errors++; $display("FAIL rnd_idx@%0d: got %0d want %0d", n, bus.entry_idx, exp_idx()); end
      if (bus.fail_count !== 2'(m_fail)) begin errors++; $display("FAIL rnd_fail@%0d: got %0d want %0d", n, bus.fail_count, m_fail); end
      if (bus.unlocked !== (m_mode == M_OPEN || m_mode == M_PROG)) begin
        errors++; $display("FAIL rnd_unlocked@%0d: got %b want %b", n, bus.unlocked, (m_mode == M_OPEN || m_mode == M_PROG));
      end
      if (bus.ready !== (m_mode == M_ENTRY || m_mode == M_PROG)) begin
        errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.ready, (m_mode == M_ENTRY || m_mode == M_PROG));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.digit_valid = 1'b0; bus.digit = 4'd0;
    bus.cancel = 1'b0; bus.relock = 1'b0; bus.prog = 1'b0;
    m_mode = M_ENTRY; m_code = c_def; m_fail = 0; m_timer = 0;
    @(negedge clk);
    test_reset();
    test_open();
    test_closed();
    test_lockout();
    test_cancel();
    test_prog();
    test_prog_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
